flappy_game_state: RTL and testbench



---
 rtl/flappy_game_state.sv | 217 +++++++++++++++++++++
 tb/tb_flappy_game_state.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/flappy_game_state.sv
// Flappy game-state engine: bird physics, wall scroll, score and
// death, advanced once per frame_tick; all outputs are registered.
module flappy_game_state #(
  parameter int BALL_X      = 100,
  parameter int BALL_Y0     = 220,
  parameter int BALL_SIZE   = 20,
  parameter int SKYBOUND    = 450,
  parameter int SCREEN_W    = 640,
  parameter int WALL_W      = 40,
  parameter int GAP         = 120,
  parameter int SCROLL      = 2,
  parameter int GRAVITY     = 1,
  parameter int FLAP_VEL    = -8,
  parameter int VMAX        = 8,
  parameter int DEAD_FRAMES = 60
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_tick,
  input  logic        flap,
  output logic [9:0]  ballX,
  output logic [9:0]  ballY,
  output logic [9:0]  wallXL,
  output logic [9:0]  wallXU,
  output logic [9:0]  wallBaseXL,
  output logic [9:0]  wallBaseXU,
  output logic [9:0]  wallYU,
  output logic [9:0]  wallYL,
  output logic [9:0]  wallBaseYU,
  output logic [9:0]  wallBaseYL,
  output logic [15:0] status
);

  typedef enum logic [1:0] {
    S_READY,
    S_PLAY,
    S_DEAD
  } state_t;

  localparam logic [9:0] LP_Y0   = 10'(BALL_Y0);
  localparam logic [9:0] LP_WX0  = 10'(SCREEN_W);
  localparam logic [9:0] LP_WYU0 = 10'd120;
  localparam logic [9:0] LP_WYL0 = 10'(120 + GAP);
  localparam logic [9:0] LP_YGND = 10'(SKYBOUND - BALL_SIZE);
  localparam logic [9:0] LP_GAP  = 10'(GAP);
  localparam logic [9:0] LP_SCR  = 10'(SCROLL);

  localparam logic signed [4:0] LP_FLAP = 5'(FLAP_VEL);
  localparam logic signed [5:0] LP_GRAV = 6'(GRAVITY);
  localparam logic signed [5:0] LP_VMAX = 6'(VMAX);
  localparam logic [7:0]        LP_DEAD = 8'(DEAD_FRAMES);

  localparam logic [10:0] LP_SIZE = 11'(BALL_SIZE);
  localparam logic [10:0] LP_SKY  = 11'(SKYBOUND);
  localparam logic [10:0] LP_BX   = 11'(BALL_X);
  localparam logic [10:0] LP_WW   = 11'(WALL_W);

  state_t            r_state, w_state;
  logic [9:0]        r_ballY, w_ballY;
  logic [9:0]        r_wallX, w_wallX;
  logic [9:0]        r_wallYU, w_wallYU;
  logic [9:0]        r_wallYL, w_wallYL;
  logic signed [4:0] r_vel, w_vel;
  logic [7:0]        r_score, w_score;
  logic [7:0]        r_cnt, w_cnt;
  logic              r_col, w_col;
  logic              r_gnd, w_gnd;
  logic [7:0]        r_lfsr;
  logic              r_flap_d;
  logic              r_pending;

  logic              w_edge;
  logic              w_pend;
  logic              w_fb;
  logic signed [10:0] w_ysum;
  logic signed [5:0] w_vinc;
  logic signed [4:0] w_vpl;
  logic [9:0]        w_yceil;
  logic [9:0]        w_ypl;
  logic              w_hit_gnd;
  logic              w_wrap;
  logic [9:0]        w_wxpl;
  logic [9:0]        w_wyupl;
  logic [9:0]        w_wylpl;
  logic [7:0]        w_scpl;
  logic              w_hit_x;
  logic              w_hit_y;
  logic              w_hit_wall;

  // An edge landing on the tick cycle still counts for that tick.
  assign w_edge = flap & ~r_flap_d;
  assign w_pend = r_pending | w_edge;
  assign w_fb   = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

  assign w_ysum = $signed({1'b0, r_ballY})
                + $signed({{6{r_vel[4]}}, r_vel});
  assign w_vinc = $signed({r_vel[4], r_vel}) + LP_GRAV;
  assign w_vpl  = w_pend ? LP_FLAP :
                  (w_vinc > LP_VMAX) ? LP_VMAX[4:0] : w_vinc[4:0];

  assign w_yceil   = w_ysum[10] ? 10'd0 : w_ysum[9:0];
  assign w_hit_gnd = ({1'b0, w_yceil} + LP_SIZE) >= LP_SKY;
  assign w_ypl     = w_hit_gnd ? LP_YGND : w_yceil;

  assign w_wrap  = r_wallX < LP_SCR;
  assign w_wxpl  = w_wrap ? LP_WX0 : r_wallX - LP_SCR;
  assign w_wyupl = w_wrap ? 10'd60 + {3'b000, r_lfsr[6:0]} : r_wallYU;
  assign w_wylpl = w_wrap ? w_wyupl + LP_GAP : r_wallYL;
  assign w_scpl  = (w_wrap && r_score != 8'hFF) ?
                   r_score + 8'd1 : r_score;

  assign w_hit_x = (LP_BX + LP_SIZE > {1'b0, w_wxpl})
                && (LP_BX < {1'b0, w_wxpl} + LP_WW);
  assign w_hit_y = ({1'b0, w_ypl} < {1'b0, w_wyupl})
                || ({1'b0, w_ypl} + LP_SIZE > {1'b0, w_wylpl});
  assign w_hit_wall = w_hit_x && w_hit_y;

  always_comb begin
    w_state  = r_state;
    w_ballY  = r_ballY;
    w_wallX  = r_wallX;
    w_wallYU = r_wallYU;
    w_wallYL = r_wallYL;
    w_vel    = r_vel;
    w_score  = r_score;
    w_cnt    = r_cnt;
    w_col    = r_col;
    w_gnd    = r_gnd;
    if (frame_tick) begin
      unique case (r_state)
        S_READY: begin
          if (w_pend) begin
            w_state = S_PLAY;
            w_vel   = LP_FLAP;
          end
        end
        S_PLAY: begin
          w_ballY  = w_ypl;
          w_vel    = w_vpl;
          w_wallX  = w_wxpl;
          w_wallYU = w_wyupl;
          w_wallYL = w_wylpl;
          w_score  = w_scpl;
          if (w_hit_gnd || w_hit_wall) begin
            w_state = S_DEAD;
            w_cnt   = LP_DEAD;
            w_gnd   = w_hit_gnd;
            w_col   = w_hit_wall;
          end
        end
        S_DEAD: begin
          if (r_cnt == 8'd0 && w_pend) begin
            w_state  = S_READY;
            w_ballY  = LP_Y0;
            w_wallX  = LP_WX0;
            w_wallYU = LP_WYU0;
            w_wallYL = LP_WYL0;
            w_vel    = '0;
            w_score  = '0;
            w_col    = 1'b0;
            w_gnd    = 1'b0;
          end else if (r_cnt != 8'd0) begin
            w_cnt = r_cnt - 8'd1;
          end
        end
        default: w_state = S_READY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_READY;
      r_ballY   <= LP_Y0;
      r_wallX   <= LP_WX0;
      r_wallYU  <= LP_WYU0;
      r_wallYL  <= LP_WYL0;
      r_vel     <= '0;
      r_score   <= '0;
      r_cnt     <= '0;
      r_col     <= 1'b0;
      r_gnd     <= 1'b0;
      r_lfsr    <= 8'hB8;
      r_flap_d  <= 1'b0;
      r_pending <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_ballY   <= w_ballY;
      r_wallX   <= w_wallX;
      r_wallYU  <= w_wallYU;
      r_wallYL  <= w_wallYL;
      r_vel     <= w_vel;
      r_score   <= w_score;
      r_cnt     <= w_cnt;
      r_col     <= w_col;
      r_gnd     <= w_gnd;
      r_lfsr    <= {r_lfsr[6:0], w_fb};
      r_flap_d  <= flap;
      r_pending <= frame_tick ? 1'b0 : (r_pending | w_edge);
    end
  end

  assign ballX      = 10'(BALL_X);
  assign ballY      = r_ballY;
  assign wallXL     = r_wallX;
  assign wallXU     = r_wallX;
  assign wallBaseXL = 10'(WALL_W);
  assign wallBaseXU = 10'(WALL_W);
  assign wallYU     = r_wallYU;
  assign wallYL     = r_wallYL;
  assign wallBaseYU = '0;
  assign wallBaseYL = 10'(SKYBOUND);
  assign status     = {r_score, 4'b0000,
                       r_state == S_DEAD, r_state == S_PLAY,
                       r_gnd, r_col};

endmodule

// File: tb/tb_flappy_game_state.sv
// Scoreboard bench for flappy_game_state: a behavioural game model
// queues expected outputs per tick, a monitor compares them.
module tb_flappy_game_state;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_tick = 1'b0;
  logic        flap = 1'b0;
  logic [9:0]  ballX, ballY, wallXL, wallXU;
  logic [9:0]  wallBaseXL, wallBaseXU, wallYU, wallYL;
  logic [9:0]  wallBaseYU, wallBaseYL;
  logic [15:0] status;

  flappy_game_state dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_tick (frame_tick),
    .flap       (flap),
    .ballX      (ballX),
    .ballY      (ballY),
    .wallXL     (wallXL),
    .wallXU     (wallXU),
    .wallBaseXL (wallBaseXL),
    .wallBaseXU (wallBaseXU),
    .wallYU     (wallYU),
    .wallYL     (wallYL),
    .wallBaseYU (wallBaseYU),
    .wallBaseYL (wallBaseYL),
    .status     (status)
  );

  always #5 clk = ~clk;

  typedef logic [115:0] vec_t;

  vec_t  exp_q[$];
  string tag_q[$];
  int    checks = 0;
  int    errors = 0;
  bit    chk_req = 1'b0;

  // game model state: 0 ready, 1 play, 2 dead
  int m_state, m_y, m_v, m_wx, m_wyu, m_wyl;
  int m_score, m_cnt;
  bit m_gnd, m_col;

  // Taps x^8+x^6+x^5+x^4 map to bits 7,5,4,3 of the shift register.
  logic [7:0] m_lfsr;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_lfsr <= 8'hB8;
    else        m_lfsr <= {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
  end

  task automatic model_reset();
    m_state = 0;
    m_y     = 220;
    m_v     = 0;
    m_wx    = 640;
    m_wyu   = 120;
    m_wyl   = 240;
    m_score = 0;
    m_cnt   = 0;
    m_gnd   = 1'b0;
    m_col   = 1'b0;
  endtask

  task automatic model_step(input bit p, input logic [7:0] lf);
    int yn, vn;
    bit g, c;
    case (m_state)
      0: if (p) begin
        m_state = 1;
        m_v     = -8;
      end
      1: begin
        yn = m_y + m_v;
        vn = p ? -8 : ((m_v + 1 > 8) ? 8 : m_v + 1);
        if (yn < 0) yn = 0;
        g = (yn + 20 >= 450);
        if (g) yn = 430;
        if (m_wx < 2) begin
          m_wx = 640;
          if (m_score < 255) m_score++;
          m_wyu = 60 + int'(lf[6:0]);
          m_wyl = m_wyu + 120;
        end else begin
          m_wx = m_wx - 2;
        end
        c = (120 > m_wx) && (100 < m_wx + 40)
            && ((yn < m_wyu) || (yn + 20 > m_wyl));
        m_y = yn;
        m_v = vn;
        if (g || c) begin
          m_state = 2;
          m_cnt   = 60;
          m_gnd   = g;
          m_col   = c;
        end
      end
      default: begin
        if (m_cnt == 0 && p) model_reset();
        else if (m_cnt > 0) m_cnt--;
      end
    endcase
  endtask

  function automatic vec_t model_vec();
    logic [15:0] st;
    st = {8'(m_score), 4'b0000, m_state == 2, m_state == 1,
          m_gnd, m_col};
    return {10'd100, 10'(m_y), 10'(m_wx), 10'(m_wx),
            10'd40, 10'd40, 10'(m_wyu), 10'(m_wyl),
            10'd0, 10'd450, st};
  endfunction

  task automatic tick(input bit fl, input bit coinc, input string tag);
    if (fl && !coinc) begin
      @(negedge clk); flap = 1'b1;
      @(negedge clk); flap = 1'b0;
    end
    @(negedge clk);
    flap       = fl && coinc;
    frame_tick = 1'b1;
    model_step(fl, m_lfsr);
    exp_q.push_back(model_vec());
    tag_q.push_back(tag);
    @(negedge clk);
    frame_tick = 1'b0;
    flap       = 1'b0;
    @(negedge clk);
  endtask

  task automatic rst_pulse(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    exp_q.push_back(model_vec());
    tag_q.push_back(tag);
    chk_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin : monitor
    vec_t  got, e;
    string t;
    forever begin
      @(posedge clk);
      if ((frame_tick && rst_n) || chk_req) begin
        @(negedge clk);
        got = {ballX, ballY, wallXL, wallXU, wallBaseXL, wallBaseXU,
               wallYU, wallYL, wallBaseYU, wallBaseYL, status};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL no_expect got %h", got);
        end else begin
          e = exp_q.pop_front();
          t = tag_q.pop_front();
          if (got !== e) begin
            errors++;
            $display("FAIL %s got y=%0d wx=%0d wyu=%0d wyl=%0d st=%h vec=%h exp y=%0d wx=%0d wyu=%0d wyl=%0d st=%h vec=%h",
                     t, got[105:96], got[95:86], got[55:46],
                     got[45:36], got[15:0], got,
                     e[105:96], e[95:86], e[55:46], e[45:36],
                     e[15:0], e);
          end
        end
        chk_req = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin : stim
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) tick(1'b0, 1'b0, "ready_hold");

    tick(1'b1, 1'b0, "start");
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, "play_fall");
    tick(1'b1, 1'b1, "flap_coinc");
    tick(1'b0, 1'b0, "after_coinc");
    rst_pulse("rst_mid_play");

    tick(1'b1, 1'b0, "start2");
    for (int n = 0; n < 200 && m_state == 1; n++)
      tick(1'b0, 1'b0, "fall_ground");
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, "dead_frozen");
    for (int d = 6; d <= 60; d++)
      tick(d == 30 || d == 60, 1'b0, "dead_wait");
    tick(1'b1, 1'b0, "restart");
    tick(1'b0, 1'b0, "ready_after");

    tick(1'b1, 1'b0, "start3");
    for (int k = 1; k <= 330; k++)
      tick(k % 17 == 0, 1'b0, "wall_pass");
    for (int n = 0; n < 200 && m_state == 1; n++)
      tick(1'b0, 1'b0, "drop");
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, "dead_score");

    rst_pulse("rst_play2");
    tick(1'b1, 1'b0, "start4");
    for (int k = 1; k <= 273; k++)
      tick(k % 17 == 0 && k <= 255, 1'b0, "approach");
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, "col_dead");

    repeat (5) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover got %0d pending exp 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
